// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and the parity
// helper used by both the transmitter and the receive-side parity checker.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity makes the total count of ones even; odd parity makes it odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses bit_tick in the last cycle of every CLKS_PER_BIT-cycle period.
// With CLKS_PER_BIT=1 the count never leaves zero, so bit_tick stays high.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic clear,
  output logic bit_tick
);

  logic [15:0] cnt;

  assign bit_tick = (cnt == 16'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx_parity.sv
// 8-bit UART transmitter with parity and a one-entry holding register.
// Frame: start(0), d0..d7, parity, stop(1); back-to-back frames when a byte is waiting.
`timescale 1ns/1ps
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Mreset,
  input  logic [DATA_BITS-1:0] Din,
  input  logic                 Din_valid,
  output logic                 Din_ready,
  output logic                 Tx_out,
  output logic                 busy,
  output logic                 done
);

  uart_state_e          state, state_next;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic                 par_q, par_next;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full, hold_full_next;
  logic                 load, accept, kill, bit_tick, tx_next;

  assign kill      = reset || Mreset;
  assign accept    = Din_valid && !hold_full;
  assign Din_ready = !hold_full;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_STOP) && bit_tick && !kill;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .clear    (kill || (state == ST_IDLE)),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift_q;
    par_next       = par_q;
    load           = 1'b0;
    tx_next        = 1'b1;

    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          state_next = ST_START;
          load       = 1'b1;
        end
      end
      ST_START: begin
        if (bit_tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt == 3'd7) begin
            state_next   = ST_PARITY;
            bit_cnt_next = 3'd0;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (hold_full) begin
            state_next = ST_START;
            load       = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next   = ST_IDLE;
        bit_cnt_next = 3'd0;
      end
    endcase

    if (load) begin
      shift_next = hold_data;
      par_next   = parity_bit(hold_data, PARITY_ODD);
    end

    // The line is registered, so it is derived from the values the FSM is about to enter.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[bit_cnt_next];
      ST_PARITY: tx_next = par_next;
      default:   tx_next = 1'b1;
    endcase

    hold_full_next = load ? 1'b0 : (accept ? 1'b1 : hold_full);
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      hold_data <= '0;
      hold_full <= 1'b0;
      Tx_out    <= 1'b1;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift_q   <= shift_next;
      par_q     <= par_next;
      hold_full <= hold_full_next;
      Tx_out    <= tx_next;
      if (accept) hold_data <= Din;
    end
  end

endmodule

// File: doc/uart_tx_parity.md
Name: uart_tx_parity

Overview:
- Transmit end of the team's 8-bit UART link with parity.
- Serialises one byte per frame: start (0), d0..d7 LSB first, parity, stop (1).
- Drives the line sampled by the team's parity-aware UART receiver state machine.
- Honours that receiver's master-reset request by aborting the current frame and idling the line.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per bit period; 1 when clk is already the baud-rate clock; legal values 1..65535.
- PARITY_ODD, 0, 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data).

Ports:
- clk  input  1  single clock, baud-rate or faster.
- reset  input  1  synchronous, active-high.
- Mreset  input  1  reset request from the receiver; synchronous, active-high; same effect as reset.
- Din  input  8  byte to send.
- Din_valid  input  1  Din is valid this cycle.
- Din_ready  output  1  holding register is empty; a byte is accepted when Din_valid && Din_ready.
- Tx_out  output  1  serial line, registered, idles high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse in the final cycle of a stop bit.

Behaviour:
- Reset values (reset or Mreset high at a clk edge): Tx_out=1, busy=0, done=0, Din_ready=1, state=Idle, holding register empty, bit counter=0, baud counter=0.
- Reset or Mreset takes priority over everything. A byte offered in the same cycle is not accepted.
- Holding register, one entry:
  - A byte is accepted on a handshake; Din_ready drops the next cycle.
  - The holding register is freed when its byte is loaded into the shifter.
  - With both holding register and shifter in use, Din_ready=0.
- Parity is computed from the byte at load into the shifter and registered with it.
- States:
  - Idle: Tx_out=1. Go to Start when the holding register is full, loading shifter and parity in that transition.
  - Start: Tx_out=0.
  - Data: 8 bit periods, d0 first; the bit counter goes 0..7.
  - Parity: Tx_out = parity bit.
  - Stop: Tx_out=1.
- Each of Start/Parity/Stop lasts exactly one bit period of CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1, then wraps and advances the state.
- End of Stop: done=1 for that cycle.
  - If the holding register is full: go directly to Start (back-to-back frame, no idle bit) and load the next byte.
  - Otherwise: go to Idle.
- Latency, CLKS_PER_BIT=1: a handshake at edge N with state Idle gives Tx_out=0 from edge N+1. A frame spans 11 cycles; the next frame's start bit follows immediately after stop.
- busy=1 in Start/Data/Parity/Stop, 0 in Idle.
- Din is never sampled while Din_ready=0. Din_valid held high with Din_ready=0 has no effect.
- Mreset mid-frame: Tx_out returns to 1 next cycle, the partial frame is discarded, the holding register is cleared, and done is not asserted.
- Mreset held high: the block stays in Idle and does not accept bytes.
- Default/illegal state encoding: go to Idle with Tx_out=1.

Decomposition:
- Shared package (uart_pkg):
  - State encodings: Idle, Start, Data, Parity, Stop.
  - Constants: DATA_BITS=8, FRAME_BITS=11.
  - Parity function (data, odd) -> bit, also reused by the receive-side parity checker.
- One sub-module, uart_baud_tick: counter producing a one-cycle bit_tick every CLKS_PER_BIT cycles, with a synchronous clear. Constant-high when CLKS_PER_BIT=1.

Test Plan:
- Single byte, CLKS_PER_BIT=1, PARITY_ODD=0, Din=0xA5 -> Tx_out sequence 0,1,0,1,0,0,1,0,1,0,1; done pulses on the 11th cycle; busy high 11 cycles; Din_ready high again once loaded.
- Parity check: Din=0x07, even -> parity bit 1; same byte with PARITY_ODD=1 -> parity bit 0. Din=0x00, even -> parity 0, full frame 0,0×8,0,1.
- Back-to-back: 0x3C then 0xC3 with Din_valid held -> second byte accepted while the first is sending, Din_ready=0 until the shifter loads. Second start bit follows the first stop bit with no idle cycle; done pulses twice, 11 cycles apart.
- CLKS_PER_BIT=4, Din=0x81 -> each bit held exactly 4 cycles; frame 44 cycles; Tx_out 0,1,0,0,0,0,0,0,1,0,1, each ×4.
- Mreset asserted during d3 of 0xFF with a byte queued -> Tx_out=1 next cycle, busy=0, Din_ready=1, no done; queued byte is not sent. A fresh 0x55 afterward transmits correctly.
- Loopback with the receiver, random 200 bytes, both parities -> every received 9-bit word equals {parity, byte}; no receiver Error state entered.
